pwm_duty_decoder: RTL and testbench

//  Receive end of the pan/tilt PWM link. Measures the two incoming PWM lines
//  (X, Y), which run at a fixed 2^WIDTH-cycle frame, and recovers each line's

---
 rtl/pwm_duty_decoder.sv | 180 ++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: receive end of the pan/tilt PWM link.
// Each line is synchronized, edge-detected and timed rise-to-rise; a frame of
// exactly 2^WIDTH samples yields its high count as the recovered duty value.

// One PWM line: synchronizer, edge detect, frame FSM, static-line timeout.
module pwm_duty_chan #(
  parameter int WIDTH   = 6,
  parameter int TIMEOUT = 256
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             pulse,
  output logic [WIDTH-1:0] duty,
  output logic             valid,
  output logic             err
);
  // Counters need headroom over a full frame and must be able to reach TIMEOUT.
  localparam int CW_FRM = WIDTH + 2;
  localparam int CW_TMO = $clog2(TIMEOUT) + 1;
  localparam int CW     = (CW_FRM > CW_TMO) ? CW_FRM : CW_TMO;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1  = CW'(TIMEOUT - 1);
  localparam logic [CW:0]   FRAME   = (CW + 1)'(2 ** WIDTH);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic   s1, s2, p, rise_q, fall_q;
  state_t state, state_n;
  logic [CW-1:0] hi, hi_n, lo, lo_n, idle, idle_n;
  logic [WIDTH-1:0] duty_n;
  logic valid_n, err_n;
  logic edge_seen, tmo;
  logic [CW:0] frame_len;

  // Two-flop synchronizer, history flop and registered edge strobes.
  // p is the line level aligned with rise_q/fall_q, so the FSM counts on p.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      p      <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= pulse;
      s2     <= s1;
      p      <= s2;
      rise_q <= s2 & ~p;
      fall_q <= ~s2 & p;
    end
  end

  assign edge_seen = rise_q | fall_q;
  // Fires on the single cycle the idle count would step onto TIMEOUT; the
  // count then parks at TIMEOUT so one static episode gives one strobe.
  assign tmo       = ~edge_seen & (idle == TMO_M1);
  assign frame_len = {1'b0, hi} + {1'b0, lo};

  // State, counters and output registers.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      idle  <= '0;
      duty  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      hi    <= hi_n;
      lo    <= lo_n;
      idle  <= idle_n;
      duty  <= duty_n;
      valid <= valid_n;
      err   <= err_n;
    end
  end

  // Next-state: frame measurement, acceptance check and static-line handling.
  always_comb begin
    state_n = state;
    hi_n    = hi;
    lo_n    = lo;
    idle_n  = idle;
    duty_n  = duty;
    valid_n = 1'b0;
    err_n   = err;

    if (edge_seen)       idle_n = '0;
    else if (idle < TMO) idle_n = idle + CW'(1);

    if (tmo) begin
      // Static low is a legitimate duty of 0; static high is a stuck line.
      duty_n  = {WIDTH{p}};
      valid_n = 1'b1;
      err_n   = err | p;
      state_n = IDLE;
      hi_n    = '0;
      lo_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_q) begin
            state_n = HIGH;
            hi_n    = CW'(1);
            lo_n    = '0;
          end
        end
        HIGH: begin
          if (fall_q) begin
            state_n = LOW;
            lo_n    = CW'(1);
          end else if (hi != CNT_MAX) begin
            hi_n = hi + CW'(1);
          end
        end
        LOW: begin
          if (rise_q) begin
            if (frame_len == FRAME) begin
              duty_n  = hi[WIDTH-1:0];
              valid_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
            state_n = HIGH;
            hi_n    = CW'(1);
            lo_n    = '0;
          end else if (lo != CNT_MAX) begin
            lo_n = lo + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// Top: two identical, independent channels (index 0 = X, 1 = Y).
module pwm_duty_decoder #(
  parameter int WIDTH   = 6,
  parameter int TIMEOUT = 256
) (
  input  logic             sysclk,
  input  logic             Reset_Sw,
  input  logic             Pulse_X,
  input  logic             Pulse_Y,
  output logic [WIDTH-1:0] Duty_X,
  output logic [WIDTH-1:0] Duty_Y,
  output logic             Valid_X,
  output logic             Valid_Y,
  output logic             Err_X,
  output logic             Err_Y
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]            pulse, valid, err;
  logic [NUM_CH-1:0][WIDTH-1:0] duty;

  assign pulse = {Pulse_Y, Pulse_X};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pwm_duty_chan #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_chan (
      .sysclk (sysclk),
      .rst_n  (Reset_Sw),
      .pulse  (pulse[g]),
      .duty   (duty[g]),
      .valid  (valid[g]),
      .err    (err[g])
    );
  end

  assign Duty_X  = duty[0];
  assign Duty_Y  = duty[1];
  assign Valid_X = valid[0];
  assign Valid_Y = valid[1];
  assign Err_X   = err[0];
  assign Err_Y   = err[1];
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed + random PWM waveforms; expected outputs come
// from an edge-timestamp model (rise-to-rise frame lengths, idle time since
// the last edge) evaluated over the whole stimulus before simulation.
module tb_pwm_duty_decoder;
  localparam int WIDTH   = 6;
  localparam int TIMEOUT = 256;
  localparam int FRAME   = 64;
  localparam int LAT     = 4;
  localparam int MAXC    = 20000;

  logic             sysclk = 1'b0;
  logic             Reset_Sw, Pulse_X, Pulse_Y;
  logic [WIDTH-1:0] Duty_X, Duty_Y;
  logic             Valid_X, Valid_Y, Err_X, Err_Y;

  pwm_duty_decoder #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .sysclk  (sysclk),
    .Reset_Sw(Reset_Sw),
    .Pulse_X (Pulse_X),
    .Pulse_Y (Pulse_Y),
    .Duty_X  (Duty_X),
    .Duty_Y  (Duty_Y),
    .Valid_X (Valid_X),
    .Valid_Y (Valid_Y),
    .Err_X   (Err_X),
    .Err_Y   (Err_Y)
  );

  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_fail = 0;

  // Stimulus per cycle: element t is driven just after posedge t.
  bit qx[$], qy[$], qr[$];
  // Spot checks with values taken straight from the scenario descriptions.
  int ms_cyc[$], ms_ch[$], ms_duty[$], ms_err[$];

  bit ev_valid [2][MAXC];
  bit ev_err   [2][MAXC];
  bit ev_rst   [2][MAXC];
  int ev_duty  [2][MAXC];
  bit exp_valid[2][MAXC];
  bit exp_err  [2][MAXC];
  int exp_duty [2][MAXC];

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // ch 0 = X, 1 = Y, 2 = reset line
  task automatic emit(input int ch, input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0)      qx.push_back(v);
      else if (ch == 1) qy.push_back(v);
      else              qr.push_back(v);
    end
  endtask

  task automatic align();
    int m;
    m = qx.size();
    if (qy.size() > m) m = qy.size();
    if (qr.size() > m) m = qr.size();
    while (qx.size() < m) qx.push_back(qx.size() > 0 ? qx[$] : 1'b0);
    while (qy.size() < m) qy.push_back(qy.size() > 0 ? qy[$] : 1'b0);
    while (qr.size() < m) qr.push_back(1'b1);
  endtask

  task automatic pwm(input int ch, input int d, input int frames);
    for (int f = 0; f < frames; f++) begin
      emit(ch, 1'b1, d);
      emit(ch, 1'b0, FRAME - d);
    end
  endtask

  task automatic mark(input int ch, input int at, input int d, input int e);
    ms_cyc.push_back(at);
    ms_ch.push_back(ch);
    ms_duty.push_back(d);
    ms_err.push_back(e);
  endtask

  // Every rise closes the frame opened by the previous rise (unless the line
  // was idle); a line unchanged for TIMEOUT samples reports its level.
  task automatic run_model(input int ch, input int n);
    bit prev, armed, v;
    int last_rise, last_fall, last_edge, duty;
    bit err;
    prev = 1'b0; armed = 1'b0;
    last_rise = 0; last_fall = 0; last_edge = -3;
    for (int t = 0; t < n; t++) begin
      v = (ch == 0) ? qx[t] : qy[t];
      if (!qr[t]) begin
        for (int c = t + 1; c <= t + LAT; c++) begin
          ev_valid[ch][c] = 1'b0;
          ev_err[ch][c]   = 1'b0;
        end
        ev_rst[ch][t+1] = 1'b1;
        prev = 1'b0; armed = 1'b0; last_edge = t - 3;
        continue;
      end
      if (v && !prev) begin
        if (armed) begin
          if (t - last_rise == FRAME) begin
            ev_valid[ch][t+LAT] = 1'b1;
            ev_duty[ch][t+LAT]  = last_fall - last_rise;
          end else begin
            ev_err[ch][t+LAT] = 1'b1;
          end
        end
        armed = 1'b1;
        last_rise = t;
      end
      if (!v && prev) last_fall = t;
      if (v != prev) last_edge = t;
      else if (t - last_edge == TIMEOUT) begin
        ev_valid[ch][t+LAT] = 1'b1;
        ev_duty[ch][t+LAT]  = v ? FRAME - 1 : 0;
        if (v) ev_err[ch][t+LAT] = 1'b1;
        armed = 1'b0;
      end
      prev = v;
    end
    duty = 0; err = 1'b0;
    for (int c = 0; c <= n; c++) begin
      if (ev_rst[ch][c]) begin duty = 0; err = 1'b0; end
      if (ev_valid[ch][c]) duty = ev_duty[ch][c];
      if (ev_err[ch][c]) err = 1'b1;
      exp_valid[ch][c] = ev_valid[ch][c];
      exp_duty[ch][c]  = duty;
      exp_err[ch][c]   = err;
    end
  endtask

  initial begin
    int n, pos, base, kind, d;

    // 1: reset held 5 cycles with both lines toggling
    for (int i = 0; i < 5; i++) begin
      qr.push_back(1'b0);
      qx.push_back(i[0] == 1'b0);
      qy.push_back(i[0] == 1'b1);
    end
    emit(0, 1'b0, 3);
    emit(1, 1'b0, 3);
    emit(2, 1'b1, 3);
    mark(0, 6, 0, 0);
    mark(1, 6, 0, 0);

    // 2: X duty 20, Y held low (times out to duty 0)
    pwm(0, 20, 3);
    pos = qx.size();
    mark(0, pos + LAT, 20, 0);
    // 4: 65-cycle frame is rejected, duty stays 20
    emit(0, 1'b1, 30);
    emit(0, 1'b0, 35);
    pos = qx.size();
    mark(0, pos + LAT, 20, 1);
    emit(0, 1'b1, 20);
    emit(0, 1'b0, 44);
    align();
    mark(1, pos + LAT, 0, 0);

    // 5: X stuck high 300 cycles, then duty 10
    pos = qx.size();
    emit(0, 1'b1, 300);
    mark(0, pos + LAT + TIMEOUT + 5, 63, 1);
    emit(0, 1'b0, 10);
    pwm(0, 10, 3);
    pos = qx.size();
    emit(0, 1'b1, 1);
    mark(0, pos + LAT, 10, 1);
    align();

    // 6: reset mid-HIGH with the high count at 15
    base = qx.size();
    emit(0, 1'b0, 4);
    emit(0, 1'b1, 21);
    emit(2, 1'b1, 22);
    emit(2, 1'b0, 3);
    align();
    mark(0, base + 23, 0, 0);
    mark(1, base + 23, 0, 0);
    emit(0, 1'b0, 10);
    pwm(0, 33, 3);
    align();

    // 3: X duty 63 (single low cycle) and Y duty 1, starting together
    pwm(0, 63, 4);
    pwm(1, 1, 4);
    pos = qx.size();
    emit(0, 1'b1, 1);
    emit(1, 1'b1, 1);
    mark(0, pos + LAT, 63, 0);
    mark(1, pos + LAT, 1, 0);
    align();

    // Random mix: good frames, bad frames, static lines, glitches, resets
    for (int k = 0; k < 30; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        kind = $urandom_range(0, 3);
        d    = $urandom_range(3, 60);
        case (kind)
          0: pwm(ch, $urandom_range(1, 63), $urandom_range(2, 4));
          1: begin
            emit(ch, 1'b1, $urandom_range(1, 70));
            emit(ch, 1'b0, $urandom_range(1, 70));
          end
          2: emit(ch, 1'($urandom_range(0, 1)), $urandom_range(250, 300));
          default: begin
            emit(ch, 1'b1, d / 2);
            emit(ch, 1'b0, 1);
            emit(ch, 1'b1, d - d / 2 - 1);
            emit(ch, 1'b0, FRAME - d);
          end
        endcase
      end
      align();
      if ($urandom_range(0, 9) == 0) begin
        emit(2, 1'b0, $urandom_range(1, 4));
        align();
      end
    end
    emit(0, 1'b0, 10);
    emit(1, 1'b0, 10);
    align();

    n = qr.size();
    if (n + LAT + 2 > MAXC) begin
      $display("FAIL stimulus_size: got %0d expected at most %0d", n, MAXC - LAT - 2);
      $fatal(1, "stimulus too long");
    end
    run_model(0, n);
    run_model(1, n);

    Reset_Sw = qr[0];
    Pulse_X  = qx[0];
    Pulse_Y  = qy[0];
    for (int c = 1; c <= n; c++) begin
      @(posedge sysclk);
      #1;
      check($sformatf("duty_x@%0d", c), Duty_X, exp_duty[0][c]);
      check($sformatf("duty_y@%0d", c), Duty_Y, exp_duty[1][c]);
      check($sformatf("valid_x@%0d", c), Valid_X, exp_valid[0][c]);
      check($sformatf("valid_y@%0d", c), Valid_Y, exp_valid[1][c]);
      check($sformatf("err_x@%0d", c), Err_X, exp_err[0][c]);
      check($sformatf("err_y@%0d", c), Err_Y, exp_err[1][c]);
      for (int m = 0; m < ms_cyc.size(); m++) begin
        if (ms_cyc[m] == c) begin
          check($sformatf("spot_duty_ch%0d@%0d", ms_ch[m], c),
                ms_ch[m] == 0 ? Duty_X : Duty_Y, ms_duty[m]);
          check($sformatf("spot_err_ch%0d@%0d", ms_ch[m], c),
                ms_ch[m] == 0 ? Err_X : Err_Y, ms_err[m]);
        end
      end
      if (c < n) begin
        Reset_Sw = qr[c];
        Pulse_X  = qx[c];
        Pulse_Y  = qy[c];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
